dcache_ctrl: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache controller.
- Sits between the MEM stage and a multi-cycle line-wide data memory.
- Generalises the single-cycle word-wide Data_Memory path: depth and line width are configurable, and a stall output freezes the pipeline on a miss.
- cpu_stall_o drives the PC write-enable and every pipeline buffer hold.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_array.sv | 66 ++++++
 rtl/dcache_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared state type and address-geometry helpers for the direct-mapped
// write-back data cache.
package dcache_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines, input int line_words);
    return ADDR_W - idx_w(num_lines) - off_w(line_words);
  endfunction

  // Keeps the word-select bus at least one bit wide for single-word lines.
  function automatic int wsel_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

  function automatic int line_w(input int line_words);
    return WORD_W * line_words;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read port and a single write
// port that either replaces a whole line (fill) or merges one word into it.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 8,
  localparam int IDX_W  = idx_w(NUM_LINES),
  localparam int TAG_W  = tag_w(NUM_LINES, LINE_WORDS),
  localparam int WSEL_W = wsel_w(LINE_WORDS),
  localparam int LINE_W = line_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_fill,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              wr_word_en,
  input  logic [WSEL_W-1:0] wr_word_sel,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              wr_dirty
);

  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [LINE_W-1:0]    wr_data;

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

  always_comb begin
    wr_data = wr_fill ? wr_line : data_mem[wr_idx];
    if (wr_word_en) wr_data[wr_word_sel*WORD_W +: WORD_W] = wr_word;
  end

  // NOTE: tag and data storage carry no reset; the valid bits alone decide
  // whether a line means anything, which keeps these arrays RAM-mappable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_data;
      if (wr_fill) tag_mem[wr_idx] <= wr_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= wr_dirty;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller between the
// MEM stage and a multi-cycle line-wide memory; stalls the pipeline on a miss.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cpu_req_i,
  input  logic                     cpu_we_i,
  input  logic [31:0]              cpu_addr_i,
  input  logic [31:0]              cpu_data_i,
  output logic [31:0]              cpu_data_o,
  output logic                     cpu_stall_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [31:0]              mem_addr_o,
  output logic [32*LINE_WORDS-1:0] mem_data_o,
  input  logic [32*LINE_WORDS-1:0] mem_data_i,
  input  logic                     mem_ack_i,
  output logic [CNT_W-1:0]         hit_cnt_o,
  output logic [CNT_W-1:0]         miss_cnt_o
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(NUM_LINES, LINE_WORDS);
  localparam int WSEL_W = wsel_w(LINE_WORDS);
  localparam int LINE_W = line_w(LINE_WORDS);

  state_t            state, state_next;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [WORD_W-1:0] req_data;
  logic              just_filled;

  logic [ADDR_W-1:0] cur_addr;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic              hit, miss;

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              wr_en, wr_fill, wr_word_en, wr_dirty;
  logic [WORD_W-1:0] wr_word;

  // While a miss is in flight only the latched request steers the array.
  assign cur_addr = (state == IDLE) ? cpu_addr_i : req_addr;
  assign idx      = cur_addr[OFF_W +: IDX_W];
  assign tag      = cur_addr[ADDR_W-1 -: TAG_W];
  assign wsel     = WSEL_W'((cur_addr >> 2) & ADDR_W'(LINE_WORDS - 1));

  assign hit  = (state == IDLE) && cpu_req_i && rd_valid && (rd_tag == tag);
  assign miss = (state == IDLE) && cpu_req_i && !hit;

  assign cpu_data_o = hit ? rd_line[wsel*WORD_W +: WORD_W] : '0;

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS)
  ) u_array (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .rd_idx     (idx),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .wr_en      (wr_en),
    .wr_idx     (idx),
    .wr_fill    (wr_fill),
    .wr_tag     (tag),
    .wr_line    (mem_data_i),
    .wr_word_en (wr_word_en),
    .wr_word_sel(wsel),
    .wr_word    (wr_word),
    .wr_dirty   (wr_dirty)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    wr_en       = 1'b0;
    wr_fill     = 1'b0;
    wr_word_en  = 1'b0;
    wr_word     = cpu_data_i;
    wr_dirty    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit && cpu_we_i) begin
          wr_en      = 1'b1;
          wr_word_en = 1'b1;
          wr_dirty   = 1'b1;
        end
        if (miss) begin
          cpu_stall_o = 1'b1;
          state_next  = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {rd_tag, idx, OFF_W'(0)};
        mem_data_o  = rd_line;
        if (mem_ack_i) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {tag, idx, OFF_W'(0)};
        if (mem_ack_i) begin
          wr_en      = 1'b1;
          wr_fill    = 1'b1;
          wr_word_en = req_we;
          wr_word    = req_data;
          wr_dirty   = req_we;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      req_addr    <= '0;
      req_we      <= 1'b0;
      req_data    <= '0;
      just_filled <= 1'b0;
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
    end else begin
      state       <= state_next;
      just_filled <= (state == ALLOCATE) && mem_ack_i;
      if (miss) begin
        req_addr <= cpu_addr_i;
        req_we   <= cpu_we_i;
        req_data <= cpu_data_i;
        if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
      // The replayed access right after a fill was already counted as a miss.
      if (hit && !just_filled && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl against a line-wide memory model that acks
// ten cycles after a request is issued.
module tb_dcache_ctrl;

  localparam int LINE_WORDS = 8;
  localparam int LINE_W     = 32 * LINE_WORDS;
  localparam int CNT_W      = 16;
  localparam int LAT        = 10;
  localparam int BOUND      = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wline;
  logic [LINE_W-1:0] mem_rline = '0;
  logic              mem_ack = 1'b0;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0]       mem_words [logic [31:0]];
  logic              force_ack = 1'b0;
  int                wb_count = 0;
  logic [31:0]       last_wb_addr = '0;
  logic [LINE_W-1:0] last_wb_line = '0;
  logic [31:0]       last_fill_addr = '0;

  dcache_ctrl #(
    .NUM_LINES (32),
    .LINE_WORDS(LINE_WORDS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_wdata),
    .cpu_data_o (cpu_rdata),
    .cpu_stall_o(cpu_stall),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wline),
    .mem_data_i (mem_rline),
    .mem_ack_i  (mem_ack),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] read_word(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'hA000_0000 | a;
  endfunction

  function automatic logic [31:0] wb_word(input int w);
    logic [LINE_W-1:0] l;
    l = last_wb_line;
    return l[w*32 +: 32];
  endfunction

  // Memory model: the first request cycle (or the ack cycle of a back-to-back
  // transfer) is cycle 0; ack is high for one edge LAT cycles later.
  initial begin : mem_model
    int  cnt;
    bit  busy;
    cnt  = 0;
    busy = 0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        busy    = 0;
        cnt     = 0;
        mem_ack = force_ack;
        if (force_ack) mem_rline = '1;
      end else if (!busy) begin
        busy    = 1;
        cnt     = 0;
        mem_ack = 1'b0;
      end else begin
        cnt++;
        if (cnt == LAT) begin
          cnt     = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            wb_count++;
            last_wb_addr = mem_addr;
            last_wb_line = mem_wline;
            for (int w = 0; w < LINE_WORDS; w++)
              mem_words[mem_addr + 32'(4*w)] = mem_wline[w*32 +: 32];
          end else begin
            last_fill_addr = mem_addr;
            for (int w = 0; w < LINE_WORDS; w++)
              mem_rline[w*32 +: 32] = read_word(mem_addr + 32'(4*w));
          end
        end else begin
          mem_ack = 1'b0;
        end
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int stall_cycles, output logic [31:0] rdata);
    bit done;
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    stall_cycles = 0;
    rdata = '0;
    done = 0;
    for (int i = 0; i < BOUND && !done; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        done  = 1;
      end else begin
        stall_cycles++;
      end
    end
    check("stall_bound_expired", 64'(!done), 64'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  initial begin : stim
    int          sc;
    logic [31:0] rd;
    int          wb_before;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 64'(cpu_stall), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_data", 64'(cpu_rdata), 64'd0);
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    rst = 1'b1;

    // Cold load: clean miss
    access(1'b0, 32'h0000_0040, '0, sc, rd);
    check("cold_stall", 64'(sc), 64'd12);
    check("cold_fill_addr", 64'(last_fill_addr), 64'h40);
    check("cold_data", 64'(rd), 64'hA000_0040);
    check("cold_miss_cnt", 64'(miss_cnt), 64'd1);
    check("cold_hit_cnt", 64'(hit_cnt), 64'd0);

    // Same line, different word: zero-latency hit
    access(1'b0, 32'h0000_0044, '0, sc, rd);
    check("hit_stall", 64'(sc), 64'd0);
    check("hit_data", 64'(rd), 64'hA000_0044);
    check("hit_cnt_1", 64'(hit_cnt), 64'd1);

    // Store hit dirties line 0x40; conflicting load forces write-back + fill
    access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, sc, rd);
    check("store_hit_stall", 64'(sc), 64'd0);
    check("hit_cnt_2", 64'(hit_cnt), 64'd2);
    access(1'b0, 32'h0000_0440, '0, sc, rd);
    check("dirty_stall", 64'(sc), 64'd22);
    check("dirty_wb_addr", 64'(last_wb_addr), 64'h40);
    check("dirty_wb_word0", 64'(wb_word(0)), 64'hDEAD_BEEF);
    check("dirty_wb_word1", 64'(wb_word(1)), 64'hA000_0044);
    check("dirty_fill_addr", 64'(last_fill_addr), 64'h440);
    check("dirty_data", 64'(rd), 64'hA000_0440);
    check("miss_cnt_2", 64'(miss_cnt), 64'd2);
    check("hit_cnt_still_2", 64'(hit_cnt), 64'd2);

    // Store miss: fill then merge, line left dirty
    access(1'b1, 32'h0000_0080, 32'h1234_5678, sc, rd);
    check("store_miss_stall", 64'(sc), 64'd12);
    check("miss_cnt_3", 64'(miss_cnt), 64'd3);
    access(1'b0, 32'h0000_0080, '0, sc, rd);
    check("merged_data", 64'(rd), 64'h1234_5678);
    check("merged_stall", 64'(sc), 64'd0);
    access(1'b0, 32'h0000_0084, '0, sc, rd);
    check("merged_neighbour", 64'(rd), 64'hA000_0084);
    check("hit_cnt_4", 64'(hit_cnt), 64'd4);
    access(1'b0, 32'h0000_0480, '0, sc, rd);
    check("evict_stall", 64'(sc), 64'd22);
    check("evict_wb_addr", 64'(last_wb_addr), 64'h80);
    check("evict_wb_word0", 64'(wb_word(0)), 64'h1234_5678);
    check("evict_data", 64'(rd), 64'hA000_0480);
    check("miss_cnt_4", 64'(miss_cnt), 64'd4);

    // Spurious ack while idle must change nothing
    wb_before = wb_count;
    @(posedge clk); #1;
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("spur_mem_req", 64'(mem_req), 64'd0);
    check("spur_stall", 64'(cpu_stall), 64'd0);
    check("spur_hit_cnt", 64'(hit_cnt), 64'd4);
    check("spur_miss_cnt", 64'(miss_cnt), 64'd4);
    check("spur_wb_count", 64'(wb_count), 64'(wb_before));
    access(1'b0, 32'h0000_0440, '0, sc, rd);
    check("spur_line_stall", 64'(sc), 64'd0);
    check("spur_line_data", 64'(rd), 64'hA000_0440);

    // Reset in the middle of a fill
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0040;
    repeat (5) @(posedge clk);
    #1;
    check("alloc_mem_req", 64'(mem_req), 64'd1);
    check("alloc_mem_we", 64'(mem_we), 64'd0);
    check("alloc_mem_addr", 64'(mem_addr), 64'h40);
    rst     = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("midrst_mem_req", 64'(mem_req), 64'd0);
    check("midrst_stall", 64'(cpu_stall), 64'd0);
    check("midrst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("midrst_miss_cnt", 64'(miss_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    access(1'b0, 32'h0000_0040, '0, sc, rd);
    check("post_rst_stall", 64'(sc), 64'd12);
    check("post_rst_data", 64'(rd), 64'hDEAD_BEEF);
    check("post_rst_miss_cnt", 64'(miss_cnt), 64'd1);
    access(1'b0, 32'h0000_0484, '0, sc, rd);
    check("post_rst_inval_stall", 64'(sc), 64'd12);
    check("post_rst_inval_data", 64'(rd), 64'hA000_0484);
    check("post_rst_miss_cnt_2", 64'(miss_cnt), 64'd2);
    check("post_rst_hit_cnt", 64'(hit_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
